serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin one addition.
REQ-005 SHALL have ports A and B, input, WIDTH each, operands sampled on the accepted start.
REQ-006 SHALL have port Cin, input, 1, carry-in sampled on the accepted start.
REQ-007 SHALL have port busy, output, 1, high while bits are being processed.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse marking a valid result.
REQ-009 SHALL have port Sum, output, WIDTH, the result.
REQ-010 SHALL have port Cout, output, 1, the final carry.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 SHALL accept start in IDLE or DONE, with the following actions:
- latch A and B into shift registers;
- load the carry flop from Cin;
- clear the bit counter;
- enter RUN.
REQ-013 SHALL, in each RUN cycle, perform one bit-serial step:
- add the operand LSBs and the carry flop with one full-adder cell;
- shift the sum bit into the MSB of the result register (right shift);
- store the cell carry in the carry flop;
- shift both operands right by one;
- increment the counter.
REQ-014 SHALL leave RUN for DONE after exactly WIDTH RUN cycles.
REQ-015 SHALL assert done for exactly the single cycle spent in DONE, then go to IDLE unless start is high, in which case it re-enters RUN.
REQ-016 SHALL behave with the following latency: start high at edge 0 gives busy high after edges 1..WIDTH and done high after edge WIDTH+1.
REQ-017 SHALL drive Sum and Cout from registers, and hold them stable from DONE until the next accepted start.
REQ-018 SHALL ignore start while in RUN, with no effect on operands, counter or carry.
REQ-019 SHALL produce the arithmetic result Sum = (A+B+Cin) mod 2^WIDTH and Cout = bit WIDTH of (A+B+Cin), with unsigned wrap-around.
REQ-020 SHALL tie busy high exactly when in RUN and done high exactly when in DONE; busy and done are never high together.

Reset
REQ-021 SHALL, on rst_n low at any time including mid-RUN, immediately force the following:
- state to IDLE;
- busy, done, Cout and carry flop to 0;
- Sum, operand registers and counter to 0.
REQ-022 SHALL discard any in-flight addition on reset; no done pulse follows reset release.

Configuration
REQ-023 SHALL, with SERIAL_ADDER_OVF_EN defined, add the output Ovf:
- width 1;
- registered;
- equal to signed overflow (the carry into the MSB step XOR Cout);
- updated with Cout;
- reset to 0.
REQ-024 SHALL, without SERIAL_ADDER_OVF_EN, have no Ovf port and no associated logic; all other behaviour is identical.

Structure
REQ-025 SHALL take the following from a shared package serial_adder_pkg:
- the FSM state encoding typedef (IDLE=0, RUN=1, DONE=2);
- the counter-width constant derived as clog2 of WIDTH+1.
REQ-026 SHALL instantiate exactly one sub-module, the team's existing full_adder cell, for the per-bit step; no other sub-modules.

Verification
REQ-027 SHALL pass: WIDTH=8, A=0x0F, B=0x01, Cin=0, start pulse -> busy high 8 cycles, done at edge 9, Sum=0x10, Cout=0.
REQ-028 SHALL pass: A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1; with the macro defined, Ovf=0.
REQ-029 SHALL pass: A=0x7F, B=0x00, Cin=1 with SERIAL_ADDER_OVF_EN -> Sum=0x80, Cout=0, Ovf=1.
REQ-030 SHALL pass: start held high during RUN with A/B changed -> result reflects the first operands only; back-to-back start in DONE -> next done exactly WIDTH+1 edges later.
REQ-031 SHALL pass: rst_n pulsed low at RUN cycle 4 -> all outputs 0 asynchronously, no done; a fresh start 0x55+0xAA, Cin=1 -> Sum=0x00, Cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Provides the FSM state encoding and the counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell.
// Ports: a, b, ci in; s (sum), co (carry) out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per RUN cycle, LSB first.
// Ports: clk, rst_n, start, A, B, Cin in; busy, done, Sum, Cout out.
// Optional Ovf (signed overflow) output with SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             cout_r;
  logic             fa_s;
  logic             fa_co;
  logic             ld;
  logic             last;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (cy),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt == LAST);

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    ld   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ld  = 1'b1;
          nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          ld  = 1'b1;
          nxt = RUN;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      cout_r <= 1'b0;
    end else if (ld) begin
      a_sr <= A;
      b_sr <= B;
      cy   <= Cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      sum_r <= {fa_s, sum_r[WIDTH-1:1]};
      cy    <= fa_co;
      cnt   <= cnt + CW'(1);
      if (last) cout_r <= fa_co;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // On the MSB step cy holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_r <= 1'b0;
    else if (!ld && state == RUN && last)
      ovf_r <= cy ^ fa_co;
  end

  assign Ovf = ovf_r;
`endif

  assign Sum  = sum_r;
  assign Cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Scoreboard of expected results, popped on each done pulse.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   n_chk;
  int   n_fail;
  exp_t sb[$];
  exp_t last_e;
  int   n_done;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .Ovf   (ovf)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic ci);
    logic [W:0]   f;
    logic [W-1:0] l;
    exp_t         e;
    f   = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    l   = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + W'(ci);
    e.s = f[W-1:0];
    e.c = f[W];
    e.o = l[W-1] ^ f[W];
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          last_e = sb.pop_front();
          chk("sum", 32'(sum), 32'(last_e.s));
          chk("cout", 32'(cout), 32'(last_e.c));
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf", 32'(ovf), 32'(last_e.o));
`endif
        end
      end
    end
  end

  // Drives start now (caller is mid-cycle) and measures the latency.
  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic ci,
                        input bit hold);
    int nb;
    int de;
    nb    = 0;
    de    = 0;
    a_in  = a;
    b_in  = b;
    cin   = ci;
    start = 1'b1;
    sb.push_back(model(a, b, ci));
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (!hold) begin
        start = 1'b0;
      end else begin
        a_in = W'($urandom);
        b_in = W'($urandom);
        cin  = 1'($urandom);
      end
      if (busy) nb++;
      if (done) begin
        de = k;
        break;
      end
    end
    start = 1'b0;
    chk("busy_cycles", 32'(nb), 32'(W));
    chk("done_edge", 32'(de), 32'(W + 1));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    n_done = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_op(8'h7F, 8'h00, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    chk("sum_hold", 32'(sum), 32'h80);
    chk("cout_hold", 32'(cout), 32'd0);

    // start held through RUN with operands changing
    @(negedge clk);
    run_op(8'h3C, 8'h5A, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    // back-to-back: start accepted in DONE
    run_op(8'h80, 8'h80, 1'b0, 1'b0);
    run_op(8'h12, 8'h34, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      @(negedge clk);
    end

    // reset during RUN cycle 4
    a_in  = 8'hF0;
    b_in  = 8'h0F;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (W + 4) @(negedge clk);
    chk("no_done_after_rst", 32'(n_done), 32'd0);

    run_op(8'h55, 8'hAA, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
